// File: rtl/colour_bbox_tracker_if.sv
// Pixel-stream input and CPU message-FIFO output of the colour bounding-box tracker.
// The slave modport is the tracker; the master modport is the pixel source / FIFO side.
interface colour_bbox_tracker_if #(
  parameter int NUM_CLASSES = 7,
  parameter int SPACE_W     = 8
);
  logic                   pix_valid;
  logic                   pix_sop;
  logic                   pix_eop;
  logic                   pix_video;
  logic [NUM_CLASSES-1:0] pix_class;
  logic [31:0]            msg_data;
  logic                   msg_valid;
  logic                   msg_ready;
  logic [SPACE_W-1:0]     msg_space;

  modport master (
    output pix_valid, pix_sop, pix_eop, pix_video, pix_class, msg_ready, msg_space,
    input  msg_data, msg_valid
  );

  modport slave (
    input  pix_valid, pix_sop, pix_eop, pix_video, pix_class, msg_ready, msg_space,
    output msg_data, msg_valid
  );
endinterface

// File: rtl/colour_bbox_tracker.sv
// Per-class bounding box and pixel-count tracker over video frames, with periodic
// message bursts of the latched results to the CPU message FIFO.
//
// state  | meaning
// S_IDLE | no burst in progress
// S_W0   | presenting class cls_q word 0 (found flag, x_min, x_max)
// S_W1   | presenting class cls_q word 1 (y_min, y_max)
module colour_bbox_tracker #(
  parameter int NUM_CLASSES  = 7,
  parameter int COORD_W      = 11,
  parameter int CNT_W        = 19,
  parameter int IMAGE_W      = 640,
  parameter int IMAGE_H      = 480,
  parameter int MSG_INTERVAL = 6,
  parameter int MIN_PIXELS   = 16,
  parameter int SPACE_W      = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  colour_bbox_tracker_if.slave           bus,
  output logic [NUM_CLASSES*COORD_W-1:0] bb_x_min,
  output logic [NUM_CLASSES*COORD_W-1:0] bb_x_max,
  output logic [NUM_CLASSES*COORD_W-1:0] bb_y_min,
  output logic [NUM_CLASSES*COORD_W-1:0] bb_y_max,
  output logic [NUM_CLASSES-1:0]         bb_found,
  output logic                           frame_ovr,
  input  logic                           ovr_clear
);

  localparam int CLS_IW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int FC_W   = $clog2(MSG_INTERVAL + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_W0   = 2'd1;
  localparam logic [1:0] S_W1   = 2'd2;

  localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(IMAGE_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(IMAGE_H - 1);
  localparam logic [COORD_W-1:0] Y_LIM      = COORD_W'(IMAGE_H);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]   MIN_C      = CNT_W'(MIN_PIXELS);
  localparam logic [SPACE_W:0]   NEED_SPACE = (SPACE_W + 1)'(2 * NUM_CLASSES);
  localparam logic [CLS_IW-1:0]  LAST_CLS   = CLS_IW'(NUM_CLASSES - 1);
  localparam logic [FC_W-1:0]    FC_RELOAD  = FC_W'(MSG_INTERVAL - 1);

  typedef logic [NUM_CLASSES-1:0][COORD_W-1:0] coord_arr_t;
  typedef logic [NUM_CLASSES-1:0][CNT_W-1:0]   cnt_arr_t;

  logic [COORD_W-1:0]     x_q, x_d, y_q, y_d;
  logic                   video_q, video_d;
  coord_arr_t             axmin_q, axmin_d, axmax_q, axmax_d;
  coord_arr_t             aymin_q, aymin_d, aymax_q, aymax_d;
  cnt_arr_t               acnt_q, acnt_d;
  coord_arr_t             bxmin_q, bxmin_d, bxmax_q, bxmax_d;
  coord_arr_t             bymin_q, bymin_d, bymax_q, bymax_d;
  logic [NUM_CLASSES-1:0] bfound_q, bfound_d;
  coord_arr_t             sxmin_q, sxmin_d, sxmax_q, sxmax_d;
  coord_arr_t             symin_q, symin_d, symax_q, symax_d;
  logic [NUM_CLASSES-1:0] sfound_q, sfound_d;
  logic [1:0]             state_q, state_d;
  logic [CLS_IW-1:0]      cls_q, cls_d;
  logic [FC_W-1:0]        fcnt_q, fcnt_d;
  logic                   ovr_q, ovr_d;

  coord_arr_t             l_xmin, l_xmax, l_ymin, l_ymax;
  logic [NUM_CLASSES-1:0] l_found;
  logic [NUM_CLASSES-1:0] hit;
  logic                   sop_beat, pix_beat, acc_en, eop_video, start_burst;
  logic [31:0]            msg_word;

  assign sop_beat  = bus.pix_valid & bus.pix_sop;
  assign pix_beat  = bus.pix_valid & ~bus.pix_sop;
  assign acc_en    = pix_beat & video_q & (y_q < Y_LIM);
  assign eop_video = pix_beat & bus.pix_eop & video_q;
  // two's-complement trick isolates the lowest set class bit (highest priority)
  assign hit       = bus.pix_class & (~bus.pix_class + 1'b1);

  // Pixel position: reset on the descriptor beat, raster-scan on every other beat.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    video_d = video_q;
    if (sop_beat) begin
      x_d     = '0;
      y_d     = '0;
      video_d = bus.pix_video;
    end else if (pix_beat) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        // hold y once past the frame so an overlong packet cannot wrap back in
        if (y_q < Y_LIM) y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Per-class accumulators: emptied at frame start, updated by the priority class hit.
  always_comb begin
    axmin_d = axmin_q;
    axmax_d = axmax_q;
    aymin_d = aymin_q;
    aymax_d = aymax_q;
    acnt_d  = acnt_q;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (sop_beat) begin
        axmin_d[k] = X_LAST;
        axmax_d[k] = '0;
        aymin_d[k] = Y_LAST;
        aymax_d[k] = '0;
        acnt_d[k]  = '0;
      end else if (acc_en && hit[k]) begin
        if (x_q < axmin_q[k]) axmin_d[k] = x_q;
        if (x_q > axmax_q[k]) axmax_d[k] = x_q;
        if (y_q < aymin_q[k]) aymin_d[k] = y_q;
        if (y_q > aymax_q[k]) aymax_d[k] = y_q;
        if (acnt_q[k] != CNT_MAX) acnt_d[k] = acnt_q[k] + 1'b1;
      end
    end
  end

  // Frame results including the current (eop) pixel; sparse classes report all-zero edges.
  always_comb begin
    l_found = '0;
    l_xmin  = '0;
    l_xmax  = '0;
    l_ymin  = '0;
    l_ymax  = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      l_found[k] = (acnt_d[k] >= MIN_C);
      if (l_found[k]) begin
        l_xmin[k] = axmin_d[k];
        l_xmax[k] = axmax_d[k];
        l_ymin[k] = aymin_d[k];
        l_ymax[k] = aymax_d[k];
      end
    end
  end

  // Frame counter, burst sequencing and overrun flag.
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    fcnt_d      = fcnt_q;
    ovr_d       = ovr_q;
    start_burst = 1'b0;
    case (state_q)
      S_W0: if (bus.msg_ready) state_d = S_W1;
      S_W1: begin
        if (bus.msg_ready) begin
          if (cls_q == LAST_CLS) begin
            state_d = S_IDLE;
            cls_d   = '0;
          end else begin
            state_d = S_W0;
            cls_d   = cls_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (ovr_clear) ovr_d = 1'b0;
    if (eop_video) begin
      if (state_q == S_IDLE) begin
        if (fcnt_q == '0) begin
          // insufficient space leaves the counter at 0 so the next frame retries
          if ({1'b0, bus.msg_space} >= NEED_SPACE) begin
            start_burst = 1'b1;
            state_d     = S_W0;
            cls_d       = '0;
            fcnt_d      = FC_RELOAD;
          end
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end else begin
        if (fcnt_q != '0) fcnt_d = fcnt_q - 1'b1;
        ovr_d = 1'b1;
      end
    end
  end

  // Latched outputs update every video frame; the snapshot only when a burst starts.
  always_comb begin
    bxmin_d  = eop_video ? l_xmin  : bxmin_q;
    bxmax_d  = eop_video ? l_xmax  : bxmax_q;
    bymin_d  = eop_video ? l_ymin  : bymin_q;
    bymax_d  = eop_video ? l_ymax  : bymax_q;
    bfound_d = eop_video ? l_found : bfound_q;
    sxmin_d  = start_burst ? l_xmin  : sxmin_q;
    sxmax_d  = start_burst ? l_xmax  : sxmax_q;
    symin_d  = start_burst ? l_ymin  : symin_q;
    symax_d  = start_burst ? l_ymax  : symax_q;
    sfound_d = start_burst ? l_found : sfound_q;
  end

  // Message word is a pure function of state and snapshot, so it is stable while stalled.
  always_comb begin
    msg_word = 32'h0;
    case (state_q)
      S_W0: msg_word = {4'hA, 4'(cls_q), sfound_q[cls_q], 1'b0,
                        11'(sxmin_q[cls_q]), 11'(sxmax_q[cls_q])};
      S_W1: msg_word = {4'hB, 4'(cls_q), 2'b00,
                        11'(symin_q[cls_q]), 11'(symax_q[cls_q])};
      default: ;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q      <= '0;
      y_q      <= '0;
      video_q  <= 1'b0;
      for (int k = 0; k < NUM_CLASSES; k++) begin
        axmin_q[k] <= X_LAST;
        axmax_q[k] <= '0;
        aymin_q[k] <= Y_LAST;
        aymax_q[k] <= '0;
        acnt_q[k]  <= '0;
      end
      bxmin_q  <= '0;
      bxmax_q  <= '0;
      bymin_q  <= '0;
      bymax_q  <= '0;
      bfound_q <= '0;
      sxmin_q  <= '0;
      sxmax_q  <= '0;
      symin_q  <= '0;
      symax_q  <= '0;
      sfound_q <= '0;
      state_q  <= S_IDLE;
      cls_q    <= '0;
      fcnt_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      video_q  <= video_d;
      axmin_q  <= axmin_d;
      axmax_q  <= axmax_d;
      aymin_q  <= aymin_d;
      aymax_q  <= aymax_d;
      acnt_q   <= acnt_d;
      bxmin_q  <= bxmin_d;
      bxmax_q  <= bxmax_d;
      bymin_q  <= bymin_d;
      bymax_q  <= bymax_d;
      bfound_q <= bfound_d;
      sxmin_q  <= sxmin_d;
      sxmax_q  <= sxmax_d;
      symin_q  <= symin_d;
      symax_q  <= symax_d;
      sfound_q <= sfound_d;
      state_q  <= state_d;
      cls_q    <= cls_d;
      fcnt_q   <= fcnt_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bb_x_min      = bxmin_q;
  assign bb_x_max      = bxmax_q;
  assign bb_y_min      = bymin_q;
  assign bb_y_max      = bymax_q;
  assign bb_found      = bfound_q;
  assign frame_ovr     = ovr_q;
  assign bus.msg_valid = (state_q != S_IDLE);
  assign bus.msg_data  = msg_word;

endmodule

// File: tb/tb_colour_bbox_tracker.sv
// Directed bench for colour_bbox_tracker on a reduced 32x24 image; expected message
// words are produced by a bench-side frame model and checked from a scoreboard queue.
module tb_colour_bbox_tracker;
  localparam int NC   = 7;
  localparam int CW   = 11;
  localparam int W    = 32;
  localparam int H    = 24;
  localparam int MI   = 6;
  localparam int MINP = 16;

  localparam int P_NONE = 0;
  localparam int P_BOX  = 1;
  localparam int P_PRIO = 2;
  localparam int P_ROW  = 3;
  localparam int P_EOP  = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               ovr_clear = 1'b0;
  logic [NC*CW-1:0]   bb_x_min, bb_x_max, bb_y_min, bb_y_max;
  logic [NC-1:0]      bb_found;
  logic               frame_ovr;

  colour_bbox_tracker_if #(.NUM_CLASSES(NC), .SPACE_W(8)) bus ();

  colour_bbox_tracker #(
    .NUM_CLASSES(NC), .COORD_W(CW), .CNT_W(19), .IMAGE_W(W), .IMAGE_H(H),
    .MSG_INTERVAL(MI), .MIN_PIXELS(MINP), .SPACE_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .bb_x_min(bb_x_min), .bb_x_max(bb_x_max), .bb_y_min(bb_y_min), .bb_y_max(bb_y_max),
    .bb_found(bb_found), .frame_ovr(frame_ovr), .ovr_clear(ovr_clear)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sbq[$];
  int          ready_mode = 1;

  int a_xmin[NC], a_xmax[NC], a_ymin[NC], a_ymax[NC], a_cnt[NC];
  int e_xmin[NC], e_xmax[NC], e_ymin[NC], e_ymax[NC];
  bit e_found[NC];
  int mc = 0;
  bit exp_ovr = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC-1:0] class_at(input int pat, input int x, input int y);
    logic [NC-1:0] c;
    c = '0;
    case (pat)
      P_BOX:  if (x >= 10 && x <= 14 && y >= 5 && y <= 8) c = 7'b0000100;
      P_PRIO: begin
        if (x >= 10 && x <= 14 && y >= 5 && y <= 8) c = 7'b0000100;
        if ((x <= 4 && y <= 3) || (x == 5 && y == 5)) c = 7'b0000110;
      end
      P_ROW:  if (y == 0 && x < 20) c = 7'b0001000;
      P_EOP:  if ((y == 20 && x < 20) || (x == W-1 && y == H-1)) c = 7'b0010000;
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NC; k++) begin
      e_xmin[k] = 0; e_xmax[k] = 0; e_ymin[k] = 0; e_ymax[k] = 0; e_found[k] = 0;
    end
    sbq.delete();
    mc = 0;
    exp_ovr = 0;
  endtask

  task automatic check_bb(input string tag);
    logic [NC*CW-1:0] ex0, ex1, ey0, ey1;
    logic [NC-1:0]    ef;
    for (int k = 0; k < NC; k++) begin
      ex0[k*CW +: CW] = CW'(e_xmin[k]);
      ex1[k*CW +: CW] = CW'(e_xmax[k]);
      ey0[k*CW +: CW] = CW'(e_ymin[k]);
      ey1[k*CW +: CW] = CW'(e_ymax[k]);
      ef[k]           = e_found[k];
    end
    chk({tag, "_x_min"}, bb_x_min, ex0);
    chk({tag, "_x_max"}, bb_x_max, ex1);
    chk({tag, "_y_min"}, bb_y_min, ey0);
    chk({tag, "_y_max"}, bb_y_max, ey1);
    chk({tag, "_found"}, bb_found, ef);
  endtask

  // Drives one packet (descriptor beat + npix pixel beats, eop on the last) and updates the model.
  task automatic send_packet(input int pat, input bit video, input int npix, input bit clr);
    bit busy, set_ovr;
    logic [NC-1:0] c;
    int x, y;
    bus.pix_valid = 1; bus.pix_sop = 1; bus.pix_eop = 0; bus.pix_video = video; bus.pix_class = '0;
    @(posedge clk); #1;
    for (int k = 0; k < NC; k++) begin
      a_xmin[k] = W-1; a_xmax[k] = 0; a_ymin[k] = H-1; a_ymax[k] = 0; a_cnt[k] = 0;
    end
    bus.pix_sop = 0; bus.pix_video = 0;
    busy = 0;
    for (int i = 0; i < npix; i++) begin
      x = i % W; y = i / W;
      c = class_at(pat, x, y);
      bus.pix_class = c;
      bus.pix_eop = (i == npix-1);
      if (i == npix-1) begin
        busy = (sbq.size() != 0);
        ovr_clear = clr;
      end
      if (video && y < H) begin
        for (int k = 0; k < NC; k++) begin
          if (c[k]) begin
            if (x < a_xmin[k]) a_xmin[k] = x;
            if (x > a_xmax[k]) a_xmax[k] = x;
            if (y < a_ymin[k]) a_ymin[k] = y;
            if (y > a_ymax[k]) a_ymax[k] = y;
            a_cnt[k]++;
            break;
          end
        end
      end
      @(posedge clk); #1;
    end
    bus.pix_valid = 0; bus.pix_eop = 0; bus.pix_class = '0; ovr_clear = 0;
    set_ovr = 0;
    if (video) begin
      for (int k = 0; k < NC; k++) begin
        e_found[k] = (a_cnt[k] >= MINP);
        e_xmin[k] = e_found[k] ? a_xmin[k] : 0;
        e_xmax[k] = e_found[k] ? a_xmax[k] : 0;
        e_ymin[k] = e_found[k] ? a_ymin[k] : 0;
        e_ymax[k] = e_found[k] ? a_ymax[k] : 0;
      end
      if (!busy) begin
        if (mc == 0) begin
          if (int'(bus.msg_space) >= 2*NC) begin
            for (int k = 0; k < NC; k++) begin
              sbq.push_back({4'hA, 4'(k), e_found[k], 1'b0, 11'(e_xmin[k]), 11'(e_xmax[k])});
              sbq.push_back({4'hB, 4'(k), 2'b00, 11'(e_ymin[k]), 11'(e_ymax[k])});
            end
            mc = MI - 1;
          end
        end else begin
          mc--;
        end
      end else begin
        if (mc != 0) mc--;
        set_ovr = 1;
      end
    end
    exp_ovr = set_ovr ? 1'b1 : (clr ? 1'b0 : exp_ovr);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drain_left"}, sbq.size(), 0);
    chk({tag, "_idle_valid"}, bus.msg_valid, 0);
  endtask

  task automatic reset_pulse();
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
    model_clear();
  endtask

  // FIFO ready pattern: 0 = stalled, 1 = always ready, 2 = toggling every cycle.
  initial begin
    bus.msg_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.msg_ready = 0;
        1: bus.msg_ready = 1;
        default: bus.msg_ready = ~bus.msg_ready;
      endcase
    end
  end

  // Scoreboard: every transfer pops one expected word; stalled words must not change.
  logic        prev_stall = 0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("msg_hold_valid", bus.msg_valid, 1);
        chk("msg_hold_data", bus.msg_data, prev_data);
      end
      if (bus.msg_valid && bus.msg_ready) begin
        checks++;
        assert (sbq.size() != 0) else begin
          errors++;
          $error("FAIL msg_unexpected: observed word %0h expected no word", bus.msg_data);
        end
        if (sbq.size() != 0) chk("msg_word", bus.msg_data, sbq.pop_front());
      end
      prev_stall = bus.msg_valid && !bus.msg_ready;
      prev_data  = bus.msg_data;
    end
  end

  initial begin
    bus.pix_valid = 0; bus.pix_sop = 0; bus.pix_eop = 0; bus.pix_video = 0; bus.pix_class = '0;
    bus.msg_space = 8'd255;
    ready_mode = 1;
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    model_clear();
    chk("rst_msg_valid", bus.msg_valid, 0);
    chk("rst_msg_data", bus.msg_data, 0);
    chk("rst_frame_ovr", frame_ovr, 0);
    check_bb("rst");
    reset_n = 1;

    // single box, first frame bursts immediately
    send_packet(P_BOX, 1, W*H, 0);
    chk("t2_burst_start", bus.msg_valid, 1);
    check_bb("t2");
    wait_drain("t2");

    // multi-hot pixels update only the lowest class
    send_packet(P_PRIO, 1, W*H, 0);
    chk("t3_no_burst", bus.msg_valid, 0);
    check_bb("t3");

    // backpressure, overrun on mid-burst eop, set beats simultaneous clear
    reset_pulse();
    ready_mode = 2;
    send_packet(P_BOX, 1, W*H, 0);
    chk("t5_burst_start", bus.msg_valid, 1);
    send_packet(P_NONE, 1, 3, 1);
    chk("t5_ovr_set_wins", frame_ovr, exp_ovr);
    check_bb("t5_mid");
    wait_drain("t5");
    ovr_clear = 1;
    @(posedge clk); #1;
    ovr_clear = 0;
    exp_ovr = 0;
    chk("t5_ovr_cleared", frame_ovr, exp_ovr);

    // reset in the middle of a stalled burst
    reset_pulse();
    ready_mode = 0;
    send_packet(P_BOX, 1, W*H, 0);
    chk("t1_burst_held", bus.msg_valid, 1);
    send_packet(P_ROW, 1, 20, 0);
    chk("t1_ovr_before_reset", frame_ovr, exp_ovr);
    check_bb("t1_pre");
    reset_n = 0;
    @(posedge clk); #1;
    model_clear();
    chk("t1_msg_valid", bus.msg_valid, 0);
    chk("t1_msg_data", bus.msg_data, 0);
    chk("t1_frame_ovr", frame_ovr, 0);
    check_bb("t1");
    reset_n = 1;

    // message interval; a non-video packet must not disturb anything
    ready_mode = 1;
    for (int f = 1; f <= 13; f++) begin
      send_packet(P_ROW, 1, 20, 0);
      chk($sformatf("t4_burst_f%0d", f), bus.msg_valid, (f == 1 || f == 7 || f == 13));
      if (f == 3) begin
        send_packet(P_BOX, 0, W*H, 0);
        chk("nv_no_burst", bus.msg_valid, 0);
        check_bb("nv");
      end
    end
    wait_drain("t4");

    // low FIFO space defers the burst; eop pixel is part of the frame
    for (int f = 0; f < 5; f++) send_packet(P_ROW, 1, 20, 0);
    chk("t6_cnt_run_down", bus.msg_valid, 0);
    bus.msg_space = 8'd10;
    send_packet(P_ROW, 1, 20, 0);
    chk("t6_low_space", bus.msg_valid, 0);
    bus.msg_space = 8'd255;
    send_packet(P_EOP, 1, W*H, 0);
    chk("t6_retry_burst", bus.msg_valid, 1);
    check_bb("t6");
    wait_drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
